// File: rtl/main_sub_pkg.sv
// Shared definitions for the main-CPU side of the sub-system handshake:
// halt sequencing states and $FD05 bit layout.
package main_sub_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HREQ   = 2'd1,
    HALTED = 2'd2,
    REL    = 2'd3
  } halt_state_t;

  localparam int         HREQ_BIT     = 7;
  localparam int         CANCEL_BIT   = 6;
  localparam int         BUSY_BIT     = 7;
  localparam logic [6:0] FD05_RD_FILL = 7'h7F;

  // Unused $FD05 read bits float high, like an undriven bus.
  function automatic logic [7:0] fd05_rd_word(input logic busy_rd);
    logic [7:0] w;
    w           = {1'b1, FD05_RD_FILL};
    w[BUSY_BIT] = busy_rd;
    return w;
  endfunction

endpackage

// File: rtl/main_sub_handshake_set_clr_flag.sv
// Set-priority SR flag with a configurable asynchronous reset value.
module set_clr_flag #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= RST_VAL;
    else if (set) q <= 1'b1;
    else if (clr) q <= 1'b0;
  end

endmodule

// File: rtl/main_sub_handshake.sv
// Main-CPU side of the sub-system handshake: $FD05 control/status, $FD04
// attention, sub-CPU HALT sequencing against BA/BS, and shared-RAM gating.
module main_sub_handshake
  import main_sub_pkg::*;
#(
  parameter int HALT_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       main_stb,
  input  logic       main_rw,
  input  logic       main_fd05_sel_n,
  input  logic       main_fd04_sel_n,
  input  logic       main_shr_sel_n,
  input  logic [7:0] main_din,
  output logic [7:0] main_dout,
  output logic       main_shr_grant,
  output logic       main_firq_n,
  input  logic       sub_stb,
  input  logic       sbusy_set_n,
  input  logic       sbusy_clr_n,
  input  logic       sirqclr_n,
  input  logic       attent_n,
  input  logic       sub_ba,
  input  logic       sub_bs,
  output logic       sub_halt_n,
  output logic       sub_irq_n,
  output logic       halted,
  output logic       halt_err
);

  localparam int CNT_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (HALT_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (HALT_TIMEOUT > 0) ? CNT_W'(HALT_TIMEOUT - 1) : '0;

  halt_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             hreq;
  logic             hreq_nxt;
  logic             busy;
  logic             cancel;
  logic             attn;
  logic             busy_rd;
  logic             wr_fd05;
  logic             rd_fd05;
  logic             rd_fd04;
  logic             unused_din;

  assign wr_fd05    = main_stb & ~main_rw & ~main_fd05_sel_n;
  assign rd_fd05    = main_stb &  main_rw & ~main_fd05_sel_n;
  assign rd_fd04    = main_stb &  main_rw & ~main_fd04_sel_n;
  assign unused_din = ^main_din[5:0];

  // The FSM acts on the value being written so HALT follows the write by one clk.
  assign hreq_nxt = wr_fd05 ? main_din[HREQ_BIT] : hreq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hreq <= 1'b0;
    else          hreq <= hreq_nxt;
  end

  set_clr_flag #(.RST_VAL(1'b1)) u_busy (
    .clk   (clk),
    .rst_n (reset_n),
    .set   (sub_stb & ~sbusy_set_n),
    .clr   (sub_stb & ~sbusy_clr_n),
    .q     (busy)
  );

  set_clr_flag #(.RST_VAL(1'b0)) u_cancel (
    .clk   (clk),
    .rst_n (reset_n),
    .set   (wr_fd05 & main_din[CANCEL_BIT]),
    .clr   (sub_stb & ~sirqclr_n),
    .q     (cancel)
  );

  set_clr_flag #(.RST_VAL(1'b0)) u_attn (
    .clk   (clk),
    .rst_n (reset_n),
    .set   (sub_stb & ~attent_n),
    .clr   (rd_fd04),
    .q     (attn)
  );

  assign sub_irq_n   = ~cancel;
  assign main_firq_n = ~attn;

  // Busy reads as set whenever a halt transition is in flight.
  assign busy_rd = busy | (state == HREQ) | (state == REL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     main_dout <= 8'hFF;
    else if (rd_fd05) main_dout <= fd05_rd_word(busy_rd);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      cnt        <= '0;
      halt_err   <= 1'b0;
      sub_halt_n <= 1'b1;
      halted     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hreq_nxt) begin
            state      <= HREQ;
            cnt        <= '0;
            sub_halt_n <= 1'b0;
          end
        end
        HREQ: begin
          if (!hreq_nxt) begin
            state      <= REL;
            cnt        <= '0;
            sub_halt_n <= 1'b1;
          end else if (sub_ba && sub_bs) begin
            state    <= HALTED;
            cnt      <= '0;
            halt_err <= 1'b0;
            halted   <= 1'b1;
          end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
            halt_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HALTED: begin
          if (!hreq_nxt) begin
            state      <= REL;
            halted     <= 1'b0;
            sub_halt_n <= 1'b1;
          end
        end
        REL: begin
          if (hreq_nxt) begin
            state      <= HREQ;
            cnt        <= '0;
            sub_halt_n <= 1'b0;
          end else if (!sub_ba) begin
            state <= RUN;
          end
        end
        default: begin
          state      <= RUN;
          sub_halt_n <= 1'b1;
          halted     <= 1'b0;
        end
      endcase
    end
  end

  // Combinational so the RAM sees the grant in the same bus cycle.
  assign main_shr_grant = halted & ~main_shr_sel_n & main_stb;

endmodule

// File: doc/main_sub_handshake.md
Name: main_sub_handshake

Overview:
Main-CPU-side counterpart of the sub-system address decoder. It implements the main CPU's $FD05 sub-control register (halt request, cancel IRQ, busy readback) and the $FD04 attention flag. It consumes the decoded sub-side strobes (busy set/clear, IRQ clear, attention) and sequences the sub-CPU HALT handshake against BA/BS. It also gates main-CPU access to the shared RAM window at $FC80-$FCFF, granting it only while the sub CPU is halted.

Parameters:
HALT_TIMEOUT, 1024, clk cycles to wait for sub BA/BS after asserting HALT before flagging halt_err (0 = no timeout).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
main_stb  in  1  one-cycle strobe; main bus cycle valid this clk
main_rw  in  1  1 = read, 0 = write
main_fd05_sel_n  in  1  decoded $FD05 select
main_fd04_sel_n  in  1  decoded $FD04 select (read clears attention)
main_shr_sel_n  in  1  decoded $FC80-$FCFF select
main_din  in  8  main write data
main_dout  out  8  read data for $FD05
main_shr_grant  out  1  shared-RAM access permitted this cycle
main_firq_n  out  1  attention interrupt to main CPU
sub_stb  in  1  one-cycle strobe; sub bus cycle valid
sbusy_set_n  in  1  sub decoded busy-set
sbusy_clr_n  in  1  sub decoded busy-clear
sirqclr_n  in  1  sub decoded cancel-IRQ clear
attent_n  in  1  sub decoded attention
sub_ba  in  1  sub CPU BA
sub_bs  in  1  sub CPU BS
sub_halt_n  out  1  HALT to sub CPU
sub_irq_n  out  1  cancel IRQ to sub CPU
halted  out  1  sub CPU confirmed halted
halt_err  out  1  sticky: halt timeout expired

Behaviour:
- Reset values: sub_halt_n=1, sub_irq_n=1, main_firq_n=1, main_dout=8'hFF, main_shr_grant=0, halted=0, halt_err=0, busy=1, state RUN, timeout counter 0.
- Sub strobes are sampled only when sub_stb=1. Main selects are sampled only when main_stb=1. All registered effects are visible on the next clk.
- Main write to $FD05:
  - bit7 = halt request (hreq).
  - bit6=1 sets cancel pending, which drives sub_irq_n=0. bit6=0 has no effect on cancel.
- Main read of $FD05: main_dout = {busy_rd, 7'h7F}, registered with 1-cycle latency. busy_rd = busy | ~halted_or_run, i.e. reads 1 in HREQ and REL.
- busy flag:
  - set by sbusy_set_n=0, cleared by sbusy_clr_n=0.
  - Both asserted in the same cycle: set wins.
- Cancel:
  - cleared by sirqclr_n=0.
  - A main bit6 set in the same cycle as sirqclr_n: set wins.
- Attention:
  - attent_n=0 sets the flag, driving main_firq_n=0.
  - A main read of $FD04 clears it.
  - Set and clear in the same cycle: set wins.
- Halt FSM states: RUN, HREQ, HALTED, REL.
  - RUN: sub_halt_n=1. hreq=1 moves to HREQ.
  - HREQ: sub_halt_n=0, timeout counter increments.
    - sub_ba=1 and sub_bs=1 moves to HALTED and clears the counter.
    - Counter reaching HALT_TIMEOUT-1 (when nonzero) sets halt_err and stays in HREQ.
    - hreq=0 moves to REL.
  - HALTED: sub_halt_n=0, halted=1. hreq=0 moves to REL.
  - REL: sub_halt_n=1. sub_ba=0 moves to RUN. hreq=1 in REL moves to HREQ.
- main_shr_grant = halted & ~main_shr_sel_n & main_stb. This is combinational, so the RAM sees it the same cycle. With no grant, the shared-RAM read mux returns 8'hFF and writes are dropped (enforced by the consumer).
- halt_err clears only on reset or on entering HALTED.
- An asynchronous reset mid-handshake immediately releases HALT (sub_halt_n=1) and drops the grant.

Decomposition:
- Shared package main_sub_pkg: halt state enum (RUN/HREQ/HALTED/REL), bit-position constants HREQ_BIT=7, CANCEL_BIT=6, BUSY_BIT=7, and FD05_RD_FILL=7'h7F.
- One natural sub-module, set_clr_flag: a set-priority SR flop with async reset value parameter, instantiated for busy, cancel and attention.

Test Plan:
- Reset release -> sub_halt_n=1, sub_irq_n=1, main_firq_n=1. $FD05 read returns 8'hFF (busy=1).
- Sub sbusy_clr_n strobe, then main reads $FD05 -> 8'h7F. Same-cycle set+clr -> next read 8'hFF.
- Main writes 8'h80 to $FD05 -> sub_halt_n=0 next clk. Sub BA=BS=1 after 5 clks -> halted=1, a main_shr_sel_n access gets grant=1. Main writes 8'h00 -> sub_halt_n=1, and RUN is reached once BA=0.
- Main access to $FC80 while in RUN -> main_shr_grant=0.
- Main writes 8'h40 -> sub_irq_n=0. sirqclr_n strobe -> sub_irq_n=1. Write 8'h40 coincident with sirqclr_n -> sub_irq_n stays 0.
- HALT_TIMEOUT=16 with BA never rising -> halt_err=1 at cycle 16 after HREQ entry. Later BA/BS=1 -> halted=1, halt_err=0. Async reset asserted in HREQ -> sub_halt_n=1 immediately.
